mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  Initiator side of the MP-8 combined instruction/data memory port. Owns the PC;
//  sequences instruction fetches and core load/store requests onto the single
//  mem port (addr/WD/WE out, RD in; async read, write on CLK rising edge).
//  Sits between the control unit/datapath and the memory. Returns fetched
//  instructions (ir) and load data (drdata).
// PARAMETERS
//  AW        5   address width (32-word memory)
//  DW        8   data width
//  RESET_PC  0   PC value after reset
// PORTS
//  CLK          in   1   clock, all state on rising edge
//  RST_N        in   1   async active-low reset
//  fetch_en     in   1   request instruction fetch at pc (level)
//  pc_load      in   1   load pc from pc_load_val this edge
//  pc_load_val  in   AW  jump/branch target
//  dreq         in   1   data access request, held until dack
//  dwe          in   1   1=store, 0=load; sampled with dreq
//  daddr        in   AW  data address; sampled with dreq
//  dwdata       in   DW  store data; sampled with dreq
//  pc           out  AW  current program counter
//  ir           out  DW  last fetched instruction
//  ir_valid     out  1   1-cycle pulse: ir updated
//  dack         out  1   1-cycle pulse: data access complete
//  drdata       out  DW  load result (valid with dack on load)
//  busy         out  1   FSM not in IDLE
//  mem_addr     out  AW  to memory addr
//  mem_wd       out  DW  to memory WD
//  mem_we       out  1   to memory WE
//  mem_rd       in   DW  from memory RD
// BEHAVIOUR
//  Reset (async, RST_N=0): state=IDLE, pc=RESET_PC, ir=0, drdata=0,
//   ir_valid=0, dack=0, last_grant=FETCH, latched req regs=0. Outputs take
//   reset values immediately, not at the next edge.
//  States: IDLE, FETCH, DATA. Each access occupies exactly one FETCH/DATA cycle.
//  IDLE: mem_addr=pc, mem_we=0, mem_wd=0. Arbitration at edge:
//   - dreq valid = dreq & !dack (dreq is ignored in the cycle dack=1).
//   - only dreq valid -> DATA; only fetch_en -> FETCH; neither -> IDLE.
//   - both: grant the one NOT equal to last_grant (round-robin); update last_grant.
//   - entering DATA latches daddr, dwdata, dwe.
//  FETCH: mem_addr=pc, mem_we=0. Edge: ir<=mem_rd, ir_valid<=1,
//   pc<=pc+1 (mod 2^AW, 31->0) -> IDLE.
//  DATA: mem_addr=latched addr, mem_we=latched dwe, mem_wd=latched data.
//   Edge: dack<=1; if load, drdata<=mem_rd (store leaves drdata unchanged) -> IDLE.
//  Latency: dreq sampled at edge N -> mem cycle N..N+1 -> dack high cycle after
//   edge N+1. Fetch identical for ir_valid. Max throughput 1 access / 2 cycles.
//  ir_valid, dack: high exactly 1 cycle, else 0.
//  pc_load: takes effect on any edge, any state; overrides the FETCH increment.
//   If pc_load coincides with the FETCH-completing edge, ir is NOT updated and
//   ir_valid stays 0 (stale fetch discarded); pc=pc_load_val.
//  Store to the address at pc while in DATA: next fetch returns the new word.
//  busy = (state != IDLE), combinational from state.
//  mem_* outputs are combinational from registered state/latches (glitch-free
//   w.r.t. core inputs; no input->mem_* combinational path).
//  Reset asserted mid-access: access aborted, mem_we falls immediately, no
//   dack/ir_valid issued.
// TESTING
//  1. Reset, mem[0]=8'hA5, fetch_en=1 two fetches -> ir_valid pulses, ir=A5 then mem[1], pc 0->1->2.
//  2. Store dwe=1 daddr=5'd20 dwdata=8'h3C, then load daddr=20 -> mem_we 1 cycle, dack twice, drdata=3C.
//  3. fetch_en and dreq held together -> grants alternate FETCH/DATA (round-robin), no starvation.
//  4. pc=31 fetch -> pc wraps to 0; pc_load=1 val=5'd9 on FETCH-completing edge -> pc=9, ir_valid=0, ir unchanged.
//  5. dreq held through dack -> only one access issued per dack; requester drop -> IDLE.
//  6. RST_N low during DATA store -> mem_we=0 immediately, no dack, pc=RESET_PC, ir=0.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// Core/memory-side bundle of the MP-8 combined instruction/data port.
// The controller uses the master modport. The core and memory use the slave modport.
// Core signals are fetch/PC control, data requests and results. Memory signals are mem_*.
interface mem_access_ctrl_if #(
  parameter int AW = 5,
  parameter int DW = 8
);
  // core -> controller
  logic          fetch_en;
  logic          pc_load;
  logic [AW-1:0] pc_load_val;
  logic          dreq;
  logic          dwe;
  logic [AW-1:0] daddr;
  logic [DW-1:0] dwdata;
  // controller -> core
  logic [AW-1:0] pc;
  logic [DW-1:0] ir;
  logic          ir_valid;
  logic          dack;
  logic [DW-1:0] drdata;
  logic          busy;
  // controller <-> memory
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wd;
  logic          mem_we;
  logic [DW-1:0] mem_rd;

  modport master (
    input  fetch_en, pc_load, pc_load_val, dreq, dwe, daddr, dwdata, mem_rd,
    output pc, ir, ir_valid, dack, drdata, busy, mem_addr, mem_wd, mem_we
  );

  modport slave (
    output fetch_en, pc_load, pc_load_val, dreq, dwe, daddr, dwdata, mem_rd,
    input  pc, ir, ir_valid, dack, drdata, busy, mem_addr, mem_wd, mem_we
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Purpose: owns the PC and arbitrates instruction fetches and load/store requests onto one memory port.
// Latency: a request sampled at edge N uses the memory in cycle N..N+1. ir_valid or dack pulses after edge N+1.
// Backpressure: dreq is held until dack, fetch_en is a level, and both contend round-robin; at most one access per 2 cycles.
module mem_access_ctrl #(
  parameter int            AW       = 5,
  parameter int            DW       = 8,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input logic CLK,
  input logic RST_N,
  mem_access_ctrl_if.master bus
);

  typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

  localparam logic GRANT_FETCH = 1'b0;
  localparam logic GRANT_DATA  = 1'b1;

  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic          dreq_v;
  logic          grant_f, grant_d;

  logic [AW-1:0] pc_q;
  logic [DW-1:0] ir_q;
  logic          ir_valid_q;
  logic          dack_q;
  logic [DW-1:0] drdata_q;

  logic [AW-1:0] lat_addr_q;
  logic [DW-1:0] lat_wd_q;
  logic          lat_we_q;

  // Arbitration in IDLE and return to IDLE after every single-cycle access.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_f = 1'b0;
    grant_d = 1'b0;
    // A held dreq must not start a second access in the cycle its dack is shown
    dreq_v  = bus.dreq & ~dack_q;
    case (state_q)
      IDLE: begin
        if (dreq_v && bus.fetch_en) begin
          if (last_q == GRANT_FETCH) grant_d = 1'b1;
          else                       grant_f = 1'b1;
        end else if (dreq_v) begin
          grant_d = 1'b1;
        end else if (bus.fetch_en) begin
          grant_f = 1'b1;
        end
        if (grant_d) begin
          state_d = DATA;
          last_d  = GRANT_DATA;
        end
        if (grant_f) begin
          state_d = FETCH;
          last_d  = GRANT_FETCH;
        end
      end
      FETCH:   state_d = IDLE;
      DATA:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state and round-robin history.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      last_q  <= GRANT_FETCH;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // PC: a jump on any edge wins over the fetch increment, which wraps at the top of memory.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pc_q <= RESET_PC;
    end else if (bus.pc_load) begin
      pc_q <= bus.pc_load_val;
    end else if (state_q == FETCH) begin
      pc_q <= pc_q + 1'b1;
    end
  end

  // Fetch completion: a jump on the same edge makes the word stale, so it is dropped.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
    end else begin
      ir_valid_q <= 1'b0;
      if (state_q == FETCH && !bus.pc_load) begin
        ir_q       <= bus.mem_rd;
        ir_valid_q <= 1'b1;
      end
    end
  end

  // Data completion: always acknowledge, and capture read data only for loads.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      dack_q   <= 1'b0;
      drdata_q <= '0;
    end else begin
      dack_q <= 1'b0;
      if (state_q == DATA) begin
        dack_q <= 1'b1;
        if (!lat_we_q) drdata_q <= bus.mem_rd;
      end
    end
  end

  // Capture the request at grant so that mem_* never depend combinationally on core inputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      lat_addr_q <= '0;
      lat_wd_q   <= '0;
      lat_we_q   <= 1'b0;
    end else if (grant_d) begin
      lat_addr_q <= bus.daddr;
      lat_wd_q   <= bus.dwdata;
      lat_we_q   <= bus.dwe;
    end
  end

  // Memory port: drive the PC unless a data access owns the port this cycle.
  always_comb begin
    bus.mem_addr = pc_q;
    bus.mem_wd   = '0;
    bus.mem_we   = 1'b0;
    if (state_q == DATA) begin
      bus.mem_addr = lat_addr_q;
      bus.mem_wd   = lat_wd_q;
      bus.mem_we   = lat_we_q;
    end
  end

  assign bus.pc       = pc_q;
  assign bus.ir       = ir_q;
  assign bus.ir_valid = ir_valid_q;
  assign bus.dack     = dack_q;
  assign bus.drdata   = drdata_q;
  assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl. Stimulus is directed scenarios followed by random transactions.
// The reference model is a shadow memory, a shadow PC and the last granted class.
// Expected completions go into a queue, and a negedge monitor pops and compares them.
module tb_mem_access_ctrl;

  logic CLK;
  logic RST_N;

  mem_access_ctrl_if #(.AW(5), .DW(8)) bus ();

  mem_access_ctrl #(.AW(5), .DW(8), .RESET_PC(5'd0)) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- memory (async read, write on rising edge) ----------------
  logic [7:0] mem      [32];
  logic [7:0] mem_init [32];
  logic       load_mem;

  assign bus.mem_rd = mem[bus.mem_addr];

  always @(posedge CLK) begin
    if (load_mem) begin
      for (int i = 0; i < 32; i++) mem[i] <= mem_init[i];
    end else if (bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_wd;
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    bit         is_fetch;
    logic [7:0] val;
    logic [4:0] pc;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] ref_mem [32];
  logic [4:0] ref_pc;
  logic [7:0] ref_ir;
  logic [7:0] ref_drdata;
  bit         ref_last_data;

  int tests;
  int fails;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_fetch();
    ev_t e;
    ref_ir = ref_mem[ref_pc];
    ref_pc = ref_pc + 5'd1;
    e.is_fetch = 1'b1;
    e.val      = ref_ir;
    e.pc       = ref_pc;
    exp_q.push_back(e);
    ref_last_data = 1'b0;
  endtask

  task automatic model_data(input bit we, input logic [4:0] a, input logic [7:0] d);
    ev_t e;
    if (we) ref_mem[a] = d;
    else    ref_drdata = ref_mem[a];
    e.is_fetch = 1'b0;
    e.val      = ref_drdata;
    e.pc       = ref_pc;
    exp_q.push_back(e);
    ref_last_data = 1'b1;
  endtask

  // When both requesters contend, the one that did not go last is served first
  task automatic model_issue(input bit wf, input bit wd, input bit we,
                             input logic [4:0] a, input logic [7:0] d);
    if (wf && wd) begin
      if (!ref_last_data) begin
        model_data(we, a, d);
        model_fetch();
      end else begin
        model_fetch();
        model_data(we, a, d);
      end
    end else if (wf) begin
      model_fetch();
    end else if (wd) begin
      model_data(we, a, d);
    end
  endtask

  task automatic model_reset();
    ref_pc        = 5'd0;
    ref_ir        = 8'h00;
    ref_drdata    = 8'h00;
    ref_last_data = 1'b0;
  endtask

  // ---------------- monitor ----------------
  always @(negedge CLK) begin
    ev_t e;
    if (RST_N) begin
      if (bus.ir_valid) begin
        if (exp_q.size() == 0 || !exp_q[0].is_fetch) begin
          check("unexpected_ir_valid", bus.ir_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("ir", bus.ir, e.val);
          check("pc_after_fetch", bus.pc, e.pc);
        end
      end
      if (bus.dack) begin
        if (exp_q.size() == 0 || exp_q[0].is_fetch) begin
          check("unexpected_dack", bus.dack, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("drdata", bus.drdata, e.val);
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Called and returning 1 time unit after a rising edge. dreq is held through its dack cycle.
  task automatic do_op(input bit wf, input bit wd, input bit we,
                       input logic [4:0] a, input logic [7:0] d);
    int cnt;
    int exp_cyc;
    bit fdone;
    bit ddone;
    model_issue(wf, wd, we, a, d);
    bus.fetch_en = wf;
    bus.dreq     = wd;
    bus.dwe      = we;
    bus.daddr    = a;
    bus.dwdata   = d;
    fdone   = !wf;
    ddone   = !wd;
    cnt     = 0;
    exp_cyc = (wf && wd) ? 4 : 2;
    while (!(fdone && ddone) && cnt < 12) begin
      @(posedge CLK);
      cnt++;
      #1;
      if (wd && ddone) bus.dreq = 1'b0;
      @(negedge CLK);
      if (wd && !wf && cnt == 1) begin
        check("data_mem_we", bus.mem_we, we);
        check("data_mem_addr", bus.mem_addr, a);
      end
      if (wf && bus.ir_valid) begin
        fdone = 1'b1;
        bus.fetch_en = 1'b0;
      end
      if (wd && bus.dack) ddone = 1'b1;
    end
    check("op_completed", {fdone, ddone}, 2'b11);
    check("op_latency", cnt, exp_cyc);
    @(posedge CLK);
    #1;
    bus.dreq     = 1'b0;
    bus.fetch_en = 1'b0;
  endtask

  task automatic jump(input logic [4:0] v);
    bus.pc_load     = 1'b1;
    bus.pc_load_val = v;
    @(posedge CLK);
    #1;
    bus.pc_load = 1'b0;
    ref_pc = v;
    check("pc_load", bus.pc, v);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [4:0] a;
    int         r;
    tests = 0;
    fails = 0;
    RST_N           = 1'b0;
    load_mem        = 1'b1;
    bus.fetch_en    = 1'b0;
    bus.pc_load     = 1'b0;
    bus.pc_load_val = '0;
    bus.dreq        = 1'b0;
    bus.dwe         = 1'b0;
    bus.daddr       = '0;
    bus.dwdata      = '0;
    for (int i = 0; i < 32; i++) mem_init[i] = 8'($urandom);
    mem_init[0] = 8'hA5;
    for (int i = 0; i < 32; i++) ref_mem[i] = mem_init[i];
    model_reset();

    // reset state
    #3;
    check("rst_pc", bus.pc, 5'd0);
    check("rst_ir", bus.ir, 8'h00);
    check("rst_ir_valid", bus.ir_valid, 1'b0);
    check("rst_dack", bus.dack, 1'b0);
    check("rst_drdata", bus.drdata, 8'h00);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_mem_we", bus.mem_we, 1'b0);
    @(posedge CLK);
    #1;
    load_mem = 1'b0;
    RST_N    = 1'b1;

    // two fetches from reset: A5 then mem[1], pc 0->1->2
    do_op(1'b1, 1'b0, 1'b0, 5'd0, 8'h00);
    do_op(1'b1, 1'b0, 1'b0, 5'd0, 8'h00);
    check("pc_after_two_fetches", bus.pc, ref_pc);

    // store then load to word 20
    do_op(1'b0, 1'b1, 1'b1, 5'd20, 8'h3C);
    do_op(1'b0, 1'b1, 1'b0, 5'd20, 8'h00);

    // both requesters held: grants must alternate
    for (int i = 0; i < 4; i++) do_op(1'b1, 1'b1, 1'b0, 5'($urandom), 8'h00);

    // store to the word at pc, then fetch it
    do_op(1'b0, 1'b1, 1'b1, ref_pc, 8'h5A);
    do_op(1'b1, 1'b0, 1'b0, 5'd0, 8'h00);

    // pc wrap 31 -> 0
    jump(5'd31);
    do_op(1'b1, 1'b0, 1'b0, 5'd0, 8'h00);
    check("pc_wrapped", bus.pc, 5'd0);

    // jump on the fetch-completing edge discards the fetched word
    bus.fetch_en = 1'b1;
    @(posedge CLK);
    #1;
    bus.fetch_en    = 1'b0;
    bus.pc_load     = 1'b1;
    bus.pc_load_val = 5'd9;
    ref_last_data   = 1'b0;
    @(posedge CLK);
    #1;
    bus.pc_load = 1'b0;
    ref_pc      = 5'd9;
    @(negedge CLK);
    check("stale_ir_valid", bus.ir_valid, 1'b0);
    check("stale_pc", bus.pc, 5'd9);
    check("stale_ir", bus.ir, ref_ir);
    @(posedge CLK);
    #1;

    // requester gone: controller returns to idle and stays there
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("idle_busy", bus.busy, 1'b0);
    @(posedge CLK);
    #1;

    // reset in the middle of a store: aborted with no write and no dack
    bus.dreq   = 1'b1;
    bus.dwe    = 1'b1;
    bus.daddr  = 5'd20;
    bus.dwdata = 8'h77;
    @(posedge CLK);
    #1;
    check("abort_mem_we_before", bus.mem_we, 1'b1);
    RST_N    = 1'b0;
    bus.dreq = 1'b0;
    #1;
    check("abort_mem_we", bus.mem_we, 1'b0);
    check("abort_pc", bus.pc, 5'd0);
    check("abort_ir", bus.ir, 8'h00);
    check("abort_dack", bus.dack, 1'b0);
    check("abort_busy", bus.busy, 1'b0);
    model_reset();
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    do_op(1'b0, 1'b1, 1'b0, 5'd20, 8'h00);

    // random traffic
    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 9);
      a = ($urandom_range(0, 3) == 0) ? ref_pc : 5'($urandom);
      if (r <= 2)      do_op(1'b1, 1'b0, 1'b0, a, 8'h00);
      else if (r <= 5) do_op(1'b0, 1'b1, 1'($urandom), a, 8'($urandom));
      else if (r <= 8) do_op(1'b1, 1'b1, 1'($urandom), a, 8'($urandom));
      else             jump(5'($urandom));
    end

    repeat (4) @(posedge CLK);
    check("pending_events", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
